// File: rtl/band_level_meter.sv
// Band level meter: windowed mean-absolute level of a Q15 sample stream,
// mapped to a 0..15 log-scale bar with a decaying peak-hold marker.
module band_level_meter #(
   parameter int WIN_LOG = 8,
   parameter int HOLD    = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [31:0] i_data,
   input  logic        i_clear,
   output logic [31:0] o_avg,
   output logic [3:0]  o_level,
   output logic [3:0]  o_peak,
   output logic        o_done
);

   localparam int ACC_W  = 32 + WIN_LOG;
   localparam int HOLD_W = $clog2(HOLD + 1);

   typedef enum logic [1:0] {
      S_ACC   = 2'd0,
      S_AVG   = 2'd1,
      S_LEVEL = 2'd2,
      S_PEAK  = 2'd3
   } state_t;

   state_t              state_r;
   logic [ACC_W-1:0]    acc_r;
   logic [WIN_LOG-1:0]  cnt_r;
   logic [HOLD_W-1:0]   hold_r;
   logic [31:0]         abs_s;
   logic [ACC_W-1:0]    sum_s;
   logic                last_s;

   // Bar height: highest set bit of the average, clipped at 15 (6 dB per step).
   function automatic logic [3:0] level_of(input logic [31:0] v);
      logic [3:0] l;
      l = 4'd0;
      if (|v[31:15]) begin
         l = 4'd15;
      end else begin
         for (int i = 0; i < 15; i++) begin
            if (v[i]) l = 4'(i);
         end
      end
      return l;
   endfunction

   // Magnitude of the incoming sample; the most negative code saturates.
   always_comb begin
      abs_s = i_data;
      if (i_data == 32'h8000_0000) begin
         abs_s = 32'h7FFF_FFFF;
      end else if (i_data[31]) begin
         abs_s = 32'd0 - i_data;
      end else begin
         abs_s = i_data;
      end
   end

   assign sum_s  = acc_r + {{WIN_LOG{1'b0}}, abs_s};
   assign last_s = (cnt_r == {WIN_LOG{1'b1}});

   // Window accumulation plus the avg -> level -> peak pipeline.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= S_ACC;
         acc_r   <= {ACC_W{1'b0}};
         cnt_r   <= {WIN_LOG{1'b0}};
         hold_r  <= {HOLD_W{1'b0}};
         o_avg   <= 32'd0;
         o_level <= 4'd0;
         o_peak  <= 4'd0;
         o_done  <= 1'b0;
      end else if (i_clear) begin
         state_r <= S_ACC;
         acc_r   <= {ACC_W{1'b0}};
         cnt_r   <= {WIN_LOG{1'b0}};
         hold_r  <= {HOLD_W{1'b0}};
         o_avg   <= 32'd0;
         o_level <= 4'd0;
         o_peak  <= 4'd0;
         o_done  <= 1'b0;
      end else begin
         // Accumulation never stalls, so samples during the pipeline start the next window.
         if (i_valid) begin
            if (last_s) begin
               o_avg <= sum_s[WIN_LOG +: 32];
               acc_r <= {ACC_W{1'b0}};
               cnt_r <= {WIN_LOG{1'b0}};
            end else begin
               acc_r <= sum_s;
               cnt_r <= cnt_r + WIN_LOG'(1);
            end
         end else begin
            acc_r <= acc_r;
         end
         o_done <= 1'b0;
         case (state_r)
            S_ACC: begin
               if (i_valid && last_s) begin
                  state_r <= S_AVG;
               end else begin
                  state_r <= S_ACC;
               end
            end
            S_AVG: begin
               o_level <= level_of(o_avg);
               state_r <= S_LEVEL;
            end
            S_LEVEL: begin
               if (o_level >= o_peak) begin
                  o_peak <= o_level;
                  hold_r <= HOLD_W'(HOLD);
               end else if (hold_r != {HOLD_W{1'b0}}) begin
                  hold_r <= hold_r - HOLD_W'(1);
               end else if ((o_peak - 4'd1) > o_level) begin
                  o_peak <= o_peak - 4'd1;
               end else begin
                  o_peak <= o_level;
               end
               o_done  <= 1'b1;
               state_r <= S_PEAK;
            end
            S_PEAK: begin
               state_r <= S_ACC;
            end
            default: begin
               state_r <= S_ACC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_band_level_meter.sv
// Self-checking bench for band_level_meter: constant-window table, randomized
// windows against an arithmetic reference model, and clear/reset/decay sequences.
module tb_band_level_meter;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic        clear;
   logic [31:0] data;
   logic [31:0] avg;
   logic [3:0]  level;
   logic [3:0]  peak;
   logic        done;

   int checks = 0;
   int failures = 0;
   int spurious = 0;
   int m_peak = 0;
   int m_hold = 0;
   logic [31:0] win_data [256];

   typedef struct {
      logic [31:0] sample;
      logic [31:0] exp_avg;
      int          exp_level;
   } vec_t;
   vec_t tbl [7];

   band_level_meter #(.WIN_LOG(8), .HOLD(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_clear(clear),
      .o_avg(avg), .o_level(level), .o_peak(peak), .o_done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic longint m_abs(input logic [31:0] d);
      longint v;
      v = longint'($signed(d));
      if (v < 0) v = -v;
      if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
      return v;
   endfunction

   function automatic int m_level(input longint a);
      int l;
      l = 0;
      if (a == 0) return 0;
      while (a > 1) begin
         a = a / 2;
         l++;
      end
      return (l > 15) ? 15 : l;
   endfunction

   function automatic int m_peak_update(input int lvl);
      if (lvl >= m_peak) begin
         m_peak = lvl;
         m_hold = 16;
      end else if (m_hold > 0) begin
         m_hold--;
      end else begin
         m_peak = (m_peak - 1 > lvl) ? m_peak - 1 : lvl;
      end
      return m_peak;
   endfunction

   task automatic drive_valid(input logic [31:0] d);
      @(negedge clk);
      valid = 1'b1;
      data  = d;
      @(negedge clk);
      valid = 1'b0;
      data  = $urandom;
   endtask

   task automatic send_plain(input logic [31:0] d);
      drive_valid(d);
      if (done) spurious++;
      repeat (2) begin
         @(negedge clk);
         if (done) spurious++;
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_peak = 0;
      m_hold = 0;
   endtask

   task automatic fill(input logic [31:0] d);
      for (int i = 0; i < 256; i++) win_data[i] = d;
   endtask

   task automatic run_window(input string tag, input logic [31:0] e_avg,
                             input int e_level, input int e_peak);
      for (int i = 0; i < 255; i++) send_plain(win_data[i]);
      drive_valid(win_data[255]);
      chk({tag, "_avg"}, avg, e_avg);
      chk({tag, "_done_t1"}, {31'd0, done}, 32'd0);
      @(negedge clk);
      chk({tag, "_level"}, {28'd0, level}, 32'(e_level));
      chk({tag, "_done_t2"}, {31'd0, done}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_t3"}, {31'd0, done}, 32'd1);
      chk({tag, "_peak"}, {28'd0, peak}, 32'(e_peak));
      @(negedge clk);
      chk({tag, "_done_t4"}, {31'd0, done}, 32'd0);
      chk({tag, "_spurious_done"}, 32'(spurious), 32'd0);
      spurious = 0;
   endtask

   task automatic model_window(input string tag);
      longint sum;
      longint e_avg;
      int     lvl;
      int     pk;
      sum = 0;
      for (int i = 0; i < 256; i++) sum += m_abs(win_data[i]);
      e_avg = sum / 256;
      lvl   = m_level(e_avg);
      pk    = m_peak_update(lvl);
      run_window(tag, e_avg[31:0], lvl, pk);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; clear = 1'b0; data = 32'd0;

      tbl[0] = '{32'h0000_4000, 32'h0000_4000, 14};
      tbl[1] = '{32'hFFFF_8000, 32'h0000_8000, 15};
      tbl[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 15};
      tbl[3] = '{32'h0000_0000, 32'h0000_0000, 0};
      tbl[4] = '{32'h0000_0001, 32'h0000_0001, 0};
      tbl[5] = '{32'h0000_0300, 32'h0000_0300, 9};
      tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 0};

      repeat (3) @(negedge clk);
      chk("rst_avg", avg, 32'd0);
      chk("rst_level", {28'd0, level}, 32'd0);
      chk("rst_peak", {28'd0, peak}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         do_clear();
         fill(tbl[v].sample);
         run_window($sformatf("tbl%0d", v), tbl[v].exp_avg, tbl[v].exp_level, tbl[v].exp_level);
      end

      do_clear();
      for (int w = 0; w < 4; w++) begin
         int sh;
         sh = $urandom_range(20, 0);
         for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom >> (1 + sh);
            if ($urandom_range(63, 0) == 0) v = 32'h8000_0000;
            else if ($urandom_range(1, 0) == 1) v = 32'd0 - v;
            win_data[i] = v;
         end
         model_window($sformatf("rand%0d", w));
      end

      // Clear together with a valid sample after 100 samples of a partial window.
      fill(32'h0000_4000);
      model_window("pre_clear");
      for (int i = 0; i < 100; i++) send_plain(32'h0000_7000);
      @(negedge clk);
      valid = 1'b1; data = 32'h7FFF_0000; clear = 1'b1;
      @(negedge clk);
      valid = 1'b0; clear = 1'b0;
      chk("clear_avg", avg, 32'd0);
      chk("clear_level", {28'd0, level}, 32'd0);
      chk("clear_peak", {28'd0, peak}, 32'd0);
      m_peak = 0; m_hold = 0;
      spurious = 0;
      fill(32'h0000_1000);
      run_window("after_clear", 32'h0000_1000, 12, 12);

      // Reset pulsed at T+2 of a completing window.
      fill(32'h0000_4000);
      for (int i = 0; i < 255; i++) send_plain(win_data[i]);
      drive_valid(32'h0000_4000);
      chk("rstp_avg_t1", avg, 32'h0000_4000);
      @(negedge clk);
      chk("rstp_level_t2", {28'd0, level}, 32'd14);
      rst = 1'b1;
      #1;
      chk("rstp_avg", avg, 32'd0);
      chk("rstp_level", {28'd0, level}, 32'd0);
      chk("rstp_peak", {28'd0, peak}, 32'd0);
      @(negedge clk);
      chk("rstp_done_t3", {31'd0, done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rstp_done_t4", {31'd0, done}, 32'd0);
      m_peak = 0; m_hold = 0;
      spurious = 0;
      fill(32'h0000_2000);
      model_window("after_rst");

      // Peak hold for 16 windows, then one step of decay per window.
      do_clear();
      fill(32'h0000_8000);
      run_window("decay0", 32'h0000_8000, 15, 15);
      fill(32'h0000_0000);
      for (int k = 1; k <= 31; k++) begin
         run_window($sformatf("decay%0d", k), 32'd0, 0, (k <= 16) ? 15 : 15 - (k - 16));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/band_level_meter.md
BAND_LEVEL_METER -- requirements
Module: band_level_meter

Interface
REQ-001 SHALL have parameter WIN_LOG, default 8, meaning log2 of samples per averaging window (WIN = 2^WIN_LOG).
REQ-002 SHALL have parameter HOLD, default 16, meaning windows the peak marker holds before decaying.
REQ-003 SHALL have port i_clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  one-cycle strobe; i_data holds a new filtered sample.
REQ-006 SHALL have port i_data  input  32  signed two's-complement Q15 sample from the upstream biquad output.
REQ-007 SHALL have port i_clear  input  1  synchronous clear of window, level and peak state.
REQ-008 SHALL have port o_avg  output  32  mean absolute sample of the last completed window, Q15.
REQ-009 SHALL have port o_level  output  4  log-scale bar height of o_avg, 0..15.
REQ-010 SHALL have port o_peak  output  4  peak-hold marker, 0..15.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse when o_level and o_peak are updated.

Function
REQ-012 SHALL compute abs = |i_data|; 0x80000000 saturates to 0x7FFFFFFF.
REQ-013 SHALL, on each i_valid, add abs to a (32+WIN_LOG)-bit unsigned accumulator and increment a WIN_LOG-bit sample counter.
REQ-014 SHALL, on the i_valid where counter == WIN-1 (cycle T), latch (acc+abs)>>WIN_LOG into o_avg at T+1, and reset acc and counter to 0 in the same edge.
REQ-015 SHALL keep accumulating i_valid samples arriving at T+1..T+3 into the new window with no sample lost.
REQ-016 SHALL set o_level at T+2: 0 if o_avg==0, else min(15, index of highest set bit of o_avg); 6 dB per step; full-scale 1.0 (0x8000) gives 15.
REQ-017 SHALL update o_peak at T+3 and pulse o_done high for exactly cycle T+3.
REQ-018 SHALL apply the peak rule: if o_level >= o_peak then o_peak = o_level and hold counter = HOLD; else if hold counter > 0 then decrement hold counter; else o_peak = max(o_peak-1, o_level).
REQ-019 SHALL implement pipeline states S_ACC -> S_AVG (T+1) -> S_LEVEL (T+2) -> S_PEAK (T+3) -> S_ACC; accumulation runs independently of state.
REQ-020 SHALL require i_valid spacing >= 4 cycles (fs 32 kHz vs system clock); behaviour for closer spacing is undefined.
REQ-021 SHALL, on i_clear, zero acc, counter, o_avg, o_level, o_peak, hold counter, return to S_ACC, suppress pending o_done; i_clear has priority over simultaneous i_valid (sample discarded).
REQ-022 SHALL never wrap the accumulator (max 0x7FFFFFFF*WIN fits 32+WIN_LOG bits).

Reset
REQ-023 SHALL, while i_rst is high, force o_avg=0, o_level=0, o_peak=0, o_done=0, acc=0, counter=0, hold=0, state S_ACC, independent of i_clk.
REQ-024 SHALL, on reset mid-pipeline, emit no o_done for the aborted window; first window after reset starts at the first post-reset i_valid.

Verification
REQ-025 SHALL pass: 256 samples of 0x00004000 -> o_avg=0x00004000, o_level=14, o_peak=14, single o_done 3 cycles after last valid.
REQ-026 SHALL pass: 256 samples of 0xFFFF8000 (-1.0) -> o_avg=0x00008000, o_level=15.
REQ-027 SHALL pass: 256 samples of 0x80000000 -> o_avg=0x7FFFFFFF, o_level=15, no overflow.
REQ-028 SHALL pass: one window at level 15 then all-zero windows -> o_peak=15 for 16 further windows, then 14, 13, ... one per window down to 0.
REQ-029 SHALL pass: i_clear asserted with i_valid after 100 samples -> counter=0, that sample dropped; next 256 samples alone define o_avg.
REQ-030 SHALL pass: i_rst pulsed at T+2 -> all outputs 0 immediately, no o_done at T+3, next full window reports normally.
